stopwatch_lap_ctrl: RTL

- Run/stop/lap sequencer between the debounced button pulses and the stopwatch timing/display datapath.
- Drives the timer `count`/`clr` controls.
- Captures split times into a small ring buffer and selects live or frozen time for the 7-segment display.
- Sits between the button processors and the timer → seg7 path; all logic on `clk`, ticks from the existing 10 Hz pulse.

---
 rtl/stopwatch_lap_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Run/stop/lap sequencer for the stopwatch: drives timer count/clr, captures laps into a ring
// buffer and selects live or frozen time for display. Optional recall: STOPWATCH_LAP_RECALL_EN.
module stopwatch_lap_ctrl #(
  parameter int unsigned LapDepth  = 4,
  parameter int unsigned HoldTicks = 30,
  parameter int unsigned HoldBits  = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        btn_ss_i,
  input  logic        btn_lap_i,
`ifdef STOPWATCH_LAP_RECALL_EN
  input  logic        btn_rcl_i,
  output logic [3:0]  rcl_idx_o,
`endif
  input  logic        tick10_i,
  input  logic [15:0] time_i,
  output logic        count_o,
  output logic        clr_o,
  output logic [15:0] disp_o,
  output logic        frozen_o,
  output logic [4:0]  lap_cnt_o,
  output logic        lap_ovf_o
);

  localparam int unsigned PtrW = (LapDepth > 1) ? $clog2(LapDepth) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StLap,
    StStop
`ifdef STOPWATCH_LAP_RECALL_EN
    , StRecall
`endif
  } state_e;

  state_e              state_q, state_d;
  logic                count_q, count_d;
  logic                clr_q, clr_d;
  logic [15:0]         disp_q, disp_d;
  logic                frozen_q, frozen_d;
  logic [4:0]          lap_cnt_q, lap_cnt_d;
  logic                lap_ovf_q, lap_ovf_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [HoldBits-1:0] hold_q, hold_d;
  logic [15:0]         lap_val_q, lap_val_d;
  logic                push, clear_laps;

`ifdef STOPWATCH_LAP_RECALL_EN
  logic [15:0]     mem_q [LapDepth];
  logic [3:0]      rcl_q, rcl_d;
  logic [PtrW-1:0] rd_ptr;
`endif

  // Next-state decode; btn_ss always takes priority over btn_lap.
  always_comb begin
    state_d    = state_q;
    clr_d      = 1'b0;
    push       = 1'b0;
    clear_laps = 1'b0;
    hold_d     = hold_q;
`ifdef STOPWATCH_LAP_RECALL_EN
    rcl_d      = rcl_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (btn_ss_i) state_d = StRun;
      end
      StRun: begin
        if (btn_ss_i) begin
          state_d = StStop;
        end else if (btn_lap_i) begin
          push    = 1'b1;
          state_d = StLap;
          hold_d  = HoldBits'(HoldTicks);
        end
      end
      StLap: begin
        if (btn_ss_i) begin
          state_d = StStop;
        end else if (btn_lap_i) begin
          push   = 1'b1;
          hold_d = HoldBits'(HoldTicks);
        end else if (tick10_i && (hold_q != '0)) begin
          // A zero hold count never expires.
          if (hold_q == HoldBits'(1)) state_d = StRun;
          hold_d = hold_q - HoldBits'(1);
        end
      end
      StStop: begin
        if (btn_ss_i) begin
          state_d = StRun;
        end else if (btn_lap_i) begin
          state_d    = StIdle;
          clr_d      = 1'b1;
          clear_laps = 1'b1;
`ifdef STOPWATCH_LAP_RECALL_EN
        end else if (btn_rcl_i && (lap_cnt_q != '0)) begin
          state_d = StRecall;
          rcl_d   = '0;
`endif
        end
      end
`ifdef STOPWATCH_LAP_RECALL_EN
      StRecall: begin
        if (btn_ss_i) begin
          state_d = StRun;
        end else if (btn_lap_i) begin
          state_d = StStop;
        end else if (btn_rcl_i) begin
          if (({1'b0, rcl_q} + 5'd1) >= lap_cnt_q) state_d = StStop;
          else rcl_d = rcl_q + 4'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef STOPWATCH_LAP_RECALL_EN
    if (state_d != StRecall) rcl_d = '0;
`endif
  end

  always_comb begin
    lap_cnt_d = lap_cnt_q;
    lap_ovf_d = lap_ovf_q;
    wr_ptr_d  = wr_ptr_q;
    lap_val_d = lap_val_q;
    if (clear_laps) begin
      lap_cnt_d = '0;
      lap_ovf_d = 1'b0;
      wr_ptr_d  = '0;
    end else if (push) begin
      lap_val_d = time_i;
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
      if (lap_cnt_q == 5'(LapDepth)) lap_ovf_d = 1'b1;
      else lap_cnt_d = lap_cnt_q + 5'd1;
    end
  end

`ifdef STOPWATCH_LAP_RECALL_EN
  // Index 0 is the newest entry, just behind the write pointer.
  assign rd_ptr = wr_ptr_q - PtrW'(1) - rcl_d[PtrW-1:0];
`endif

  always_comb begin
    count_d  = (state_d == StRun) || (state_d == StLap);
    frozen_d = (state_d == StLap);
    disp_d   = time_i;
    if (state_d == StLap) disp_d = lap_val_d;
`ifdef STOPWATCH_LAP_RECALL_EN
    if (state_d == StRecall) begin
      frozen_d = 1'b1;
      disp_d   = mem_q[rd_ptr];
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= 1'b0;
      clr_q     <= 1'b1;
      disp_q    <= time_i;
      frozen_q  <= 1'b0;
      lap_cnt_q <= '0;
      lap_ovf_q <= 1'b0;
      wr_ptr_q  <= '0;
      hold_q    <= '0;
      lap_val_q <= '0;
`ifdef STOPWATCH_LAP_RECALL_EN
      rcl_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      clr_q     <= clr_d;
      disp_q    <= disp_d;
      frozen_q  <= frozen_d;
      lap_cnt_q <= lap_cnt_d;
      lap_ovf_q <= lap_ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      hold_q    <= hold_d;
      lap_val_q <= lap_val_d;
`ifdef STOPWATCH_LAP_RECALL_EN
      rcl_q     <= rcl_d;
`endif
    end
  end

`ifdef STOPWATCH_LAP_RECALL_EN
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem_q[wr_ptr_q] <= time_i;
  end

  assign rcl_idx_o = rcl_q;
`endif

  assign count_o   = count_q;
  assign clr_o     = clr_q;
  assign disp_o    = disp_q;
  assign frozen_o  = frozen_q;
  assign lap_cnt_o = lap_cnt_q;
  assign lap_ovf_o = lap_ovf_q;

endmodule
